ahb_slave_if_p: RTL and testbench
=================================

# ahb_slave_if_p

Parametrised AHB-side front end for the AHB-to-APB bridge. It decodes the AHB address into NUM_SLV one-hot APB peripheral selects and qualifies transfers. It holds two-stage address/data/write pipelines that stall on wait states and generates a protocol-correct two-cycle ERROR response for unmapped accesses. It sits between the AHB master and the bridge APB controller FSM, replacing the fixed 32-bit/3-peripheral front end.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLV, 3, number of APB peripherals (1..8)
- BASE_ADDR, 32'h8000_0000, start of decoded window (ADDR_W bits)
- REGION_LOG2, 26, log2 of bytes per peripheral region (64 MB default)
- CNT_W, 8, error counter width

Ports:
- Hclk  in  1  bridge clock, all state on rising edge
- Hreset  in  1  reset, asynchronous, active-high
- Hwrite  in  1  AHB write
- Hreadyin  in  1  AHB HREADY from interconnect
- Htrans  in  2  AHB transfer type
- Haddr  in  ADDR_W  AHB address
- Hwdata  in  DATA_W  AHB write data
- Prdata  in  DATA_W  APB read data from controller
- bridge_ready  in  1  APB controller can complete current data phase
- Haddr1, Haddr2  out  ADDR_W  address pipeline stages 1, 2
- Hwdata1, Hwdata2  out  DATA_W  write-data pipeline stages 1, 2
- Hwritereg, Hwritereg1  out  1  write pipeline stages 1, 2
- valid  out  1  qualified mapped transfer this cycle
- tempselx  out  NUM_SLV  one-hot peripheral select (combinational)
- Hresp  out  2  AHB response, 2'b00 OKAY, 2'b01 ERROR
- Hreadyout  out  1  AHB HREADYOUT
- Hrdata  out  DATA_W  read data, = Prdata combinationally
- err_cnt  out  CNT_W  saturating count of ERROR responses issued

## Operation
- Region i (0..NUM_SLV-1) is [BASE_ADDR + i·2^REGION_LOG2, BASE_ADDR + (i+1)·2^REGION_LOG2). Compare and subtract at ADDR_W+1 bits so the top region cannot wrap. Index = (Haddr − BASE_ADDR) >> REGION_LOG2.
- Legal parameter sets satisfy BASE_ADDR + NUM_SLV·2^REGION_LOG2 ≤ 2^ADDR_W. Elaboration fails otherwise.
- tempselx[i]=1 iff Haddr is in region i; all zero outside the window.
- active = Hreadyin & Htrans[1] (NONSEQ or SEQ). IDLE and BUSY are never active.
- valid = active & (tempselx != 0).
- unmapped = active & (tempselx == 0) & (state == IDLE or ERR2).
- Pipelines advance only when Hreadyin=1 (hold during wait states): Haddr1←Haddr, Haddr2←Haddr1, Hwdata1←Hwdata, Hwdata2←Hwdata1, Hwritereg←Hwrite, Hwritereg1←Hwritereg.
- Response FSM, states IDLE/ERR1/ERR2:
  - IDLE: Hresp=OKAY, Hreadyout=bridge_ready. On unmapped, go to ERR1.
  - ERR1: Hresp=ERROR, Hreadyout=0. Always go to ERR2.
  - ERR2: Hresp=ERROR, Hreadyout=1. On unmapped, go to ERR1 (back-to-back error). Otherwise go to IDLE.
- In ERR1 and ERR2, bridge_ready is ignored. valid may assert in ERR2 for a new mapped transfer; its data phase starts in IDLE.
- err_cnt increments on every transition into ERR1 and saturates at 2^CNT_W−1.

## Timing
- Reset (async assert, sync-safe deassert):
  - All pipeline registers = 0; err_cnt = 0; state = IDLE.
  - Hresp = 2'b00; Hreadyout = bridge_ready.
  - Combinational outputs follow their inputs.
- Reset mid-error (ERR1/ERR2): next output is IDLE/OKAY immediately on assert.
- Pipeline latency is 1 cycle per stage on Hreadyin-high cycles. A stage holds for any number of Hreadyin-low cycles.
- Error latency: unmapped transfer sampled at edge N → ERR1 during cycle N+1 → ERR2 during N+2 → IDLE at N+3 unless another unmapped transfer arrives.
- The address phase presented during ERR1 is not decoded for errors; Hreadyin is low there from the master.
- valid, tempselx and Hrdata have zero latency (combinational).

## Test plan
- Reset: assert Hreset mid-cycle with Hclk stopped. Required: Haddr1/2 = 0, Hwdata1/2 = 0, Hwritereg/1 = 0, err_cnt = 0, Hresp = 00 asynchronously.
- Decode defaults: Haddr = 0x8000_0000 / 0x87FF_FFFC / 0x8800_0000 / 0x8C00_0000 with NONSEQ, Hreadyin=1. Required: tempselx = 001 / 010 / 100 / 000; valid = 1, 1, 1, 0.
- Wait-state hold: write to 0x8000_0010 with data 0xA5A5_0001, then Hreadyin=0 for 3 cycles. Required: Haddr1 = 0x8000_0010 held for all 3 cycles; Haddr2 advances only after Hreadyin returns high.
- Error response: NONSEQ to 0x9000_0000. Required: next cycle Hresp=01/Hreadyout=0, then Hresp=01/Hreadyout=1, then OKAY; err_cnt = 1. Repeat back-to-back from ERR2: ERR1 re-entered, err_cnt = 2.
- Saturation and params: with CNT_W=2, issue 5 errors → err_cnt = 3. With NUM_SLV=8, REGION_LOG2=12, BASE=0xFFFF_8000: Haddr 0xFFFF_F000 → tempselx = 8'h80, no wrap.
- Flow control: mapped read, bridge_ready low for 2 cycles. Required: Hreadyout = 0 for 2 cycles, Hrdata tracks Prdata = 0x1234_5678, Hresp stays 00.

Source files
------------

// File: rtl/ahb_slave_if_p_if.sv
// ahb_slave_if_p_if: AHB-side bus bundle for the bridge front end.
//   slave  modport: view taken by ahb_slave_if_p (decoder/pipeline/response)
//   master modport: view taken by the AHB master / APB controller side
// Signals: Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, bridge_ready (to slave);
//          Haddr1/2, Hwdata1/2, Hwritereg/1, valid, tempselx, Hresp,
//          Hreadyout, Hrdata, err_cnt (from slave).
interface ahb_slave_if_p_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 3,
  parameter int unsigned CNT_W   = 8
);
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
  logic              bridge_ready;

  logic [ADDR_W-1:0]  Haddr1;
  logic [ADDR_W-1:0]  Haddr2;
  logic [DATA_W-1:0]  Hwdata1;
  logic [DATA_W-1:0]  Hwdata2;
  logic               Hwritereg;
  logic               Hwritereg1;
  logic               valid;
  logic [NUM_SLV-1:0] tempselx;
  logic [1:0]         Hresp;
  logic               Hreadyout;
  logic [DATA_W-1:0]  Hrdata;
  logic [CNT_W-1:0]   err_cnt;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, bridge_ready,
    output Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
           valid, tempselx, Hresp, Hreadyout, Hrdata, err_cnt
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, bridge_ready,
    input  Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
           valid, tempselx, Hresp, Hreadyout, Hrdata, err_cnt
  );
endinterface

// File: rtl/ahb_slave_if_p.sv
// ahb_slave_if_p: AHB front end of the AHB-to-APB bridge.
// Decodes Haddr into NUM_SLV one-hot selects, qualifies transfers, keeps
// two-stage address/data/write pipelines that hold on wait states, and
// answers unmapped accesses with a two-cycle ERROR response.
// Ports:
//   Hclk   - clock, all state on rising edge
//   Hreset - asynchronous active-high reset
//   bus    - ahb_slave_if_p_if.slave bundle (AHB inputs, APB read data,
//            pipeline stages, selects, response, error counter)
module ahb_slave_if_p #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       REGION_LOG2 = 26,
  parameter int unsigned       CNT_W       = 8
) (
  input logic               Hclk,
  input logic               Hreset,
  ahb_slave_if_p_if.slave   bus
);

  localparam int unsigned OFF_W = ADDR_W + 1;
  localparam int unsigned CHK_W = ADDR_W + 5;
  localparam logic [CHK_W-1:0] WIN_END =
    CHK_W'(BASE_ADDR) + (CHK_W'(NUM_SLV) << REGION_LOG2);
  localparam logic [CHK_W-1:0] ADDR_SPACE = CHK_W'(1) << ADDR_W;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Reject parameter sets whose decode window overruns the address space.
  if (NUM_SLV < 1 || NUM_SLV > 8 || REGION_LOG2 > ADDR_W ||
      WIN_END > ADDR_SPACE) begin : g_param_err
    $error("ahb_slave_if_p: illegal NUM_SLV/BASE_ADDR/REGION_LOG2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0]   off_c;
  logic [OFF_W-1:0]   idx_c;
  logic               in_win_c;
  logic [NUM_SLV-1:0] sel_c;
  logic               active_c;
  logic               unmapped_c;
  logic [1:0]         hresp_c;
  logic               hreadyout_c;

  logic [ADDR_W-1:0]  haddr1_q, haddr2_q;
  logic [DATA_W-1:0]  hwdata1_q, hwdata2_q;
  logic               hwrite1_q, hwrite2_q;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // Offset computed one bit wider so addresses below BASE_ADDR show up as a
  // borrow instead of wrapping into a region.
  assign off_c    = {1'b0, bus.Haddr} - {1'b0, BASE_ADDR};
  assign in_win_c = ~off_c[ADDR_W];
  assign idx_c    = off_c >> REGION_LOG2;

  // One-hot region select; indices beyond NUM_SLV-1 match no bit.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel_c[i] = in_win_c && (idx_c == OFF_W'(i));
    end
  end

  assign active_c   = bus.Hreadyin & bus.Htrans[1];
  assign unmapped_c = active_c & ~(|sel_c) &
                      ((state_q == ST_IDLE) || (state_q == ST_ERR2));

  // Response FSM state register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Response FSM next state and outputs.
  always_comb begin
    state_d     = state_q;
    hresp_c     = RESP_OKAY;
    hreadyout_c = bus.bridge_ready;
    case (state_q)
      ST_IDLE: begin
        if (unmapped_c) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hresp_c     = RESP_ERROR;
        hreadyout_c = 1'b0;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_c     = RESP_ERROR;
        hreadyout_c = 1'b1;
        state_d     = unmapped_c ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating error counter; unmapped_c is exactly the entry into ERR1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (unmapped_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  // Address/data/write pipelines advance only on Hreadyin-high cycles.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite1_q <= 1'b0;
      hwrite2_q <= 1'b0;
    end else if (bus.Hreadyin) begin
      haddr1_q  <= bus.Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= bus.Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite1_q <= bus.Hwrite;
      hwrite2_q <= hwrite1_q;
    end
  end

  assign bus.Haddr1     = haddr1_q;
  assign bus.Haddr2     = haddr2_q;
  assign bus.Hwdata1    = hwdata1_q;
  assign bus.Hwdata2    = hwdata2_q;
  assign bus.Hwritereg  = hwrite1_q;
  assign bus.Hwritereg1 = hwrite2_q;
  assign bus.valid      = active_c & (|sel_c);
  assign bus.tempselx   = sel_c;
  assign bus.Hresp      = hresp_c;
  assign bus.Hreadyout  = hreadyout_c;
  assign bus.Hrdata     = bus.Prdata;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ahb_slave_if_p.sv
// Directed bench for ahb_slave_if_p: default instance plus an 8-peripheral,
// 4 KB-region, 2-bit-counter instance at the top of the address space.
module tb_ahb_slave_if_p;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic Hclk;
  logic Hreset;
  bit   clk_en;
  int   total;
  int   passed;
  int   fails;

  ahb_slave_if_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .CNT_W(8)) bus0 ();
  ahb_slave_if_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(8), .CNT_W(2)) bus1 ();

  ahb_slave_if_p #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .BASE_ADDR(32'h8000_0000),
    .REGION_LOG2(26), .CNT_W(8)
  ) dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .bus(bus0)
  );

  ahb_slave_if_p #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(8), .BASE_ADDR(32'hFFFF_8000),
    .REGION_LOG2(12), .CNT_W(2)
  ) dut1 (
    .Hclk(Hclk), .Hreset(Hreset), .bus(bus1)
  );

  initial Hclk = 1'b0;
  always #5 if (clk_en) Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive0(input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [31:0] wdata, input logic rdy);
    bus0.Haddr    = addr;
    bus0.Htrans   = trans;
    bus0.Hwrite   = wr;
    bus0.Hwdata   = wdata;
    bus0.Hreadyin = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    clk_en = 1'b0;
    Hreset = 1'b0;
    drive0(32'h0, T_IDLE, 1'b0, 32'h0, 1'b1);
    bus0.Prdata       = 32'h0;
    bus0.bridge_ready = 1'b1;
    bus1.Haddr        = 32'h0;
    bus1.Htrans       = T_IDLE;
    bus1.Hwrite       = 1'b0;
    bus1.Hwdata       = 32'h0;
    bus1.Hreadyin     = 1'b1;
    bus1.Prdata       = 32'h0;
    bus1.bridge_ready = 1'b1;

    // Asynchronous reset with the clock stopped
    #3 Hreset = 1'b1;
    #1;
    check("rst_haddr1",   64'(bus0.Haddr1), 64'h0);
    check("rst_haddr2",   64'(bus0.Haddr2), 64'h0);
    check("rst_hwdata1",  64'(bus0.Hwdata1), 64'h0);
    check("rst_hwdata2",  64'(bus0.Hwdata2), 64'h0);
    check("rst_hwrite1",  64'(bus0.Hwritereg), 64'h0);
    check("rst_hwrite2",  64'(bus0.Hwritereg1), 64'h0);
    check("rst_errcnt",   64'(bus0.err_cnt), 64'h0);
    check("rst_hresp",    64'(bus0.Hresp), 64'h0);
    check("rst_hreadyout", 64'(bus0.Hreadyout), 64'h1);
    check("rst_errcnt_p", 64'(bus1.err_cnt), 64'h0);
    clk_en = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0;
    tick();

    // Default decode
    drive0(32'h8000_0000, T_NONSEQ, 1'b0, 32'h0, 1'b1);
    #1 check("dec_r0_sel", 64'(bus0.tempselx), 64'h1);
    check("dec_r0_valid", 64'(bus0.valid), 64'h1);
    bus0.Haddr = 32'h87FF_FFFC;
    #1 check("dec_r1_sel", 64'(bus0.tempselx), 64'h2);
    check("dec_r1_valid", 64'(bus0.valid), 64'h1);
    bus0.Haddr = 32'h8800_0000;
    #1 check("dec_r2_sel", 64'(bus0.tempselx), 64'h4);
    check("dec_r2_valid", 64'(bus0.valid), 64'h1);
    bus0.Haddr = 32'h8C00_0000;
    #1 check("dec_out_sel", 64'(bus0.tempselx), 64'h0);
    check("dec_out_valid", 64'(bus0.valid), 64'h0);
    bus0.Haddr = 32'h7FFF_FFFC;
    #1 check("dec_below_sel", 64'(bus0.tempselx), 64'h0);
    bus0.Haddr  = 32'h8000_0000;
    bus0.Htrans = T_BUSY;
    #1 check("dec_busy_valid", 64'(bus0.valid), 64'h0);
    check("dec_busy_sel", 64'(bus0.tempselx), 64'h1);
    drive0(32'h0, T_IDLE, 1'b0, 32'h0, 1'b1);
    tick();

    // Wait-state hold
    drive0(32'h8000_0010, T_NONSEQ, 1'b1, 32'hA5A5_0001, 1'b1);
    tick();
    check("ws_haddr1_cap", 64'(bus0.Haddr1), 64'h8000_0010);
    check("ws_haddr2_cap", 64'(bus0.Haddr2), 64'h0);
    check("ws_hwdata1_cap", 64'(bus0.Hwdata1), 64'hA5A5_0001);
    check("ws_hwrite1_cap", 64'(bus0.Hwritereg), 64'h1);
    drive0(32'h8000_0020, T_NONSEQ, 1'b0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ws_haddr1_hold%0d", k), 64'(bus0.Haddr1), 64'h8000_0010);
      check($sformatf("ws_haddr2_hold%0d", k), 64'(bus0.Haddr2), 64'h0);
      check($sformatf("ws_hwdata1_hold%0d", k), 64'(bus0.Hwdata1), 64'hA5A5_0001);
    end
    drive0(32'h8000_0020, T_IDLE, 1'b0, 32'hDEAD_BEEF, 1'b1);
    tick();
    check("ws_haddr1_adv", 64'(bus0.Haddr1), 64'h8000_0020);
    check("ws_haddr2_adv", 64'(bus0.Haddr2), 64'h8000_0010);
    check("ws_hwdata2_adv", 64'(bus0.Hwdata2), 64'hA5A5_0001);
    check("ws_hwrite1_adv", 64'(bus0.Hwritereg), 64'h0);
    check("ws_hwrite2_adv", 64'(bus0.Hwritereg1), 64'h1);

    // Error response, ERR1 not decoded, back-to-back from ERR2
    drive0(32'h9000_0000, T_NONSEQ, 1'b0, 32'h0, 1'b1);
    #1 check("err_pre_hresp", 64'(bus0.Hresp), 64'h0);
    check("err_pre_valid", 64'(bus0.valid), 64'h0);
    tick();
    check("err1_hresp", 64'(bus0.Hresp), 64'h1);
    check("err1_hready", 64'(bus0.Hreadyout), 64'h0);
    check("err1_cnt", 64'(bus0.err_cnt), 64'h1);
    tick();
    check("err2_hresp", 64'(bus0.Hresp), 64'h1);
    check("err2_hready", 64'(bus0.Hreadyout), 64'h1);
    check("err2_cnt_noinc", 64'(bus0.err_cnt), 64'h1);
    tick();
    check("b2b_err1_hresp", 64'(bus0.Hresp), 64'h1);
    check("b2b_err1_hready", 64'(bus0.Hreadyout), 64'h0);
    check("b2b_cnt", 64'(bus0.err_cnt), 64'h2);
    drive0(32'h9000_0000, T_IDLE, 1'b0, 32'h0, 1'b0);
    tick();
    check("b2b_err2_hresp", 64'(bus0.Hresp), 64'h1);
    check("b2b_err2_hready", 64'(bus0.Hreadyout), 64'h1);
    drive0(32'h8400_0000, T_NONSEQ, 1'b0, 32'h0, 1'b1);
    #1 check("err2_map_valid", 64'(bus0.valid), 64'h1);
    check("err2_map_sel", 64'(bus0.tempselx), 64'h2);
    tick();
    check("err_done_hresp", 64'(bus0.Hresp), 64'h0);
    check("err_done_hready", 64'(bus0.Hreadyout), 64'h1);
    check("err_done_cnt", 64'(bus0.err_cnt), 64'h2);
    check("err_done_haddr1", 64'(bus0.Haddr1), 64'h8400_0000);

    // Reset asserted while in ERR1
    drive0(32'h9000_0000, T_NONSEQ, 1'b0, 32'h0, 1'b1);
    tick();
    check("rsterr_pre_hresp", 64'(bus0.Hresp), 64'h1);
    check("rsterr_pre_cnt", 64'(bus0.err_cnt), 64'h3);
    drive0(32'h0, T_IDLE, 1'b0, 32'h0, 1'b1);
    #2 Hreset = 1'b1;
    #1;
    check("rsterr_hresp", 64'(bus0.Hresp), 64'h0);
    check("rsterr_hready", 64'(bus0.Hreadyout), 64'h1);
    check("rsterr_cnt", 64'(bus0.err_cnt), 64'h0);
    check("rsterr_haddr1", 64'(bus0.Haddr1), 64'h0);
    @(negedge Hclk);
    Hreset = 1'b0;
    tick();
    check("rsterr_post_hresp", 64'(bus0.Hresp), 64'h0);

    // Flow control on a mapped read
    drive0(32'h8000_0040, T_NONSEQ, 1'b0, 32'h0, 1'b1);
    bus0.Prdata       = 32'h1234_5678;
    bus0.bridge_ready = 1'b0;
    #1 check("fc_valid", 64'(bus0.valid), 64'h1);
    check("fc0_hready", 64'(bus0.Hreadyout), 64'h0);
    check("fc0_hrdata", 64'(bus0.Hrdata), 64'h1234_5678);
    check("fc0_hresp", 64'(bus0.Hresp), 64'h0);
    tick();
    drive0(32'h8000_0040, T_IDLE, 1'b0, 32'h0, 1'b0);
    #1 check("fc1_hready", 64'(bus0.Hreadyout), 64'h0);
    check("fc1_hrdata", 64'(bus0.Hrdata), 64'h1234_5678);
    check("fc1_hresp", 64'(bus0.Hresp), 64'h0);
    tick();
    bus0.bridge_ready = 1'b1;
    bus0.Prdata       = 32'hCAFE_F00D;
    bus0.Hreadyin     = 1'b1;
    #1 check("fc2_hready", 64'(bus0.Hreadyout), 64'h1);
    check("fc2_hrdata", 64'(bus0.Hrdata), 64'hCAFE_F00D);
    check("fc2_hresp", 64'(bus0.Hresp), 64'h0);

    // Parametrised instance: top-of-space decode
    bus1.Htrans = T_NONSEQ;
    bus1.Haddr  = 32'hFFFF_F000;
    #1 check("p_top_sel", 64'(bus1.tempselx), 64'h80);
    check("p_top_valid", 64'(bus1.valid), 64'h1);
    bus1.Haddr = 32'hFFFF_FFFC;
    #1 check("p_last_sel", 64'(bus1.tempselx), 64'h80);
    bus1.Haddr = 32'hFFFF_8000;
    #1 check("p_base_sel", 64'(bus1.tempselx), 64'h01);
    bus1.Haddr = 32'hFFFF_7FFC;
    #1 check("p_below_sel", 64'(bus1.tempselx), 64'h00);
    check("p_below_valid", 64'(bus1.valid), 64'h0);

    // Counter saturation: continuous unmapped NONSEQ gives 5 ERR1 entries
    bus1.Haddr = 32'h0000_0000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) check("p_cnt_2", 64'(bus1.err_cnt), 64'h2);
      if (k == 5) check("p_cnt_3", 64'(bus1.err_cnt), 64'h3);
    end
    check("p_cnt_sat", 64'(bus1.err_cnt), 64'h3);
    check("p_sat_hresp", 64'(bus1.Hresp), 64'h1);
    check("p_sat_hready", 64'(bus1.Hreadyout), 64'h0);
    bus1.Htrans = T_IDLE;
    tick();
    tick();
    check("p_end_hresp", 64'(bus1.Hresp), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
